// File: rtl/pc_stack_unit_pkg.sv
// Shared command codes and width helpers for the program-counter / return-stack unit.
package pc_stack_unit_pkg;

  typedef enum logic [2:0] {
    CMD_INC  = 3'd0,
    CMD_JMP  = 3'd1,
    CMD_JPG  = 3'd2,
    CMD_CALL = 3'd3,
    CMD_RET  = 3'd4,
    CMD_HOLD = 3'd5
  } cmd_e;

  // A one-entry ring still needs a one-bit pointer signal.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int nib_width(input int addr_w);
    return (addr_w > 4) ? $clog2(addr_w / 4) : 1;
  endfunction

endpackage

// File: rtl/pc_stack_unit_if.sv
// Command/status bundle between a sequencer (master) and pc_stack_unit (slave).
interface pc_stack_unit_if
  import pc_stack_unit_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 7
);
  localparam int NIB_W = nib_width(ADDR_W);
  localparam int SP_W  = $clog2(DEPTH + 1);

  logic              cmd_valid;
  logic [2:0]        cmd;
  logic [ADDR_W-1:0] tgt;
  logic              clr_flags;
  logic [NIB_W-1:0]  nib_sel;
  logic [ADDR_W-1:0] pc;
  logic [3:0]        nib_out;
  logic [SP_W-1:0]   sp;
  logic              full;
  logic              empty;
  logic              ovf;
  logic              udf;

  modport master (
    output cmd_valid, cmd, tgt, clr_flags, nib_sel,
    input  pc, nib_out, sp, full, empty, ovf, udf
  );

  modport slave (
    input  cmd_valid, cmd, tgt, clr_flags, nib_sel,
    output pc, nib_out, sp, full, empty, ovf, udf
  );

endinterface

// File: rtl/pc_stack_unit_mem.sv
// DEPTH x ADDR_W ring LIFO: a full push overwrites the oldest entry, an empty pop is ignored.
module pc_stack_mem
  import pc_stack_unit_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 7,
  localparam int PTR_W = ptr_width(DEPTH),
  localparam int SP_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] dout,
  output logic [SP_W-1:0]   sp,
  output logic [PTR_W-1:0]  top
);

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;

  // wr_ptr is the next free slot; when full it is also the oldest entry.
  assign top  = (wr_ptr == '0) ? PTR_W'(DEPTH - 1) : wr_ptr - 1'b1;
  assign dout = (sp == '0) ? '0 : mem[top];

  // NOTE: the stack must read as all-zero after reset, so the array is reset
  // explicitly; a RAM-style array without reset would power up undefined.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      sp     <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= din;
      wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (sp != SP_W'(DEPTH)) sp <= sp + 1'b1;
    end else if (pop && sp != '0) begin
      wr_ptr <= top;
      sp     <= sp - 1'b1;
    end
  end

endmodule

// File: rtl/pc_stack_unit.sv
// Program counter with next-pc mux, return-address ring stack, sticky flags and nibble output.
module pc_stack_unit
  import pc_stack_unit_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 7,
  parameter int PAGE_W = 8
) (
  input  logic             cp2,
  input  logic             reset,
  pc_stack_unit_if.slave   bus
);

  localparam int NIB_W = nib_width(ADDR_W);
  localparam int PTR_W = ptr_width(DEPTH);
  localparam int SP_W  = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] pc_q, next_pc, top_entry;
  logic [3:0]        nib_q, nib_next;
  logic [SP_W-1:0]   sp;
  logic [PTR_W-1:0]  top_ptr;
  logic              ovf_q, udf_q, push, pop, set_ovf, set_udf, full, empty;

  assign full  = (sp == SP_W'(DEPTH));
  assign empty = (sp == '0);

  pc_stack_mem #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_mem (
    .clk   (cp2),
    .rst_n (reset),
    .push  (push),
    .pop   (pop),
    .din   (pc_q),
    .dout  (top_entry),
    .sp    (sp),
    .top   (top_ptr)
  );

  // NOTE: every output of this block gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    next_pc = pc_q;
    push    = 1'b0;
    pop     = 1'b0;
    set_ovf = 1'b0;
    set_udf = 1'b0;
    if (bus.cmd_valid) begin
      case (bus.cmd)
        CMD_INC:  next_pc = pc_q + ADDR_W'(1);
        CMD_JMP:  next_pc = bus.tgt;
        CMD_JPG:  next_pc = {pc_q[ADDR_W-1:PAGE_W], bus.tgt[PAGE_W-1:0]};
        CMD_CALL: begin
          push    = 1'b1;
          next_pc = bus.tgt;
          set_ovf = full;
        end
        CMD_RET: begin
          // An empty stack reads as zero, so an underflowing return lands at 0.
          pop     = 1'b1;
          next_pc = top_entry;
          set_udf = empty;
        end
        default: ;
      endcase
    end
  end

  // Out-of-range nibble indices match no iteration and leave the zero default.
  always_comb begin
    nib_next = '0;
    for (int i = 0; i < ADDR_W / 4; i++) begin
      if (bus.nib_sel == NIB_W'(i)) nib_next = next_pc[4*i +: 4];
    end
  end

  // NOTE: registers are written with non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge cp2 or negedge reset) begin
    if (!reset) begin
      pc_q  <= '0;
      nib_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      pc_q  <= next_pc;
      nib_q <= nib_next;
      ovf_q <= (ovf_q & ~bus.clr_flags) | set_ovf;
      udf_q <= (udf_q & ~bus.clr_flags) | set_udf;
    end
  end

  assign bus.pc      = pc_q;
  assign bus.nib_out = nib_q;
  assign bus.sp      = sp;
  assign bus.full    = full;
  assign bus.empty   = empty;
  assign bus.ovf     = ovf_q;
  assign bus.udf     = udf_q;

endmodule
